// File: rtl/fsk_tick_gen_if.sv
// Control, configuration and status bundle of the FSK tick/tone generator.
// The master drives run control and modulus writes, and the slave (the
// generator) returns the count, tick, wave and status.
interface fsk_tick_gen_if #(
  parameter int N = 16
);
  logic         en;
  logic         clr;
  logic         sym;
  logic         cfg_we;
  logic         cfg_sel;
  logic [N-1:0] cfg_data;
  logic         cfg_err;
  logic         max_tick;
  logic [N-1:0] q;
  logic         wave;
  logic         active_sym;

  modport master (
    output en, clr, sym, cfg_we, cfg_sel, cfg_data,
    input  cfg_err, max_tick, q, wave, active_sym
  );

  modport slave (
    input  en, clr, sym, cfg_we, cfg_sel, cfg_data,
    output cfg_err, max_tick, q, wave, active_sym
  );
endinterface

// File: rtl/fsk_tick_gen.sv
// Dual-modulus tick/tone generator. It divides clk by the mark or space
// modulus. The symbol and the modulus are only (re)loaded at a counter wrap or
// at start-up, so the generated tone changes frequency without a phase jump.
module fsk_tick_gen #(
  parameter int N      = 16,
  parameter int M0_DEF = 163,
  parameter int M1_DEF = 326
) (
  input  logic              clk,
  input  logic              reset,
  fsk_tick_gen_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [N-1:0] MIN_MOD = N'(2);
  localparam logic [N-1:0] ONE     = N'(1);

  state_t       r_state;
  state_t       w_state_next;
  logic [N-1:0] r_q;
  logic [N-1:0] w_q_next;
  logic [N-1:0] r_m_act;
  logic [N-1:0] w_m_act_next;
  logic         r_wave;
  logic         w_wave_next;
  logic         r_active_sym;
  logic         w_active_sym_next;
  logic         r_cfg_err;
  logic [N-1:0] r_mod [2];
  logic [N-1:0] w_m_sel;
  logic [N-1:0] w_last;
  logic         w_at_last;
  logic         w_cfg_ok;

  // Index 0 is space (m0) and index 1 is mark (m1). The requested symbol picks the reload value directly.
  assign w_m_sel   = r_mod[bus.sym];
  assign w_last    = r_m_act - ONE;
  assign w_at_last = (r_q == w_last);
  assign w_cfg_ok  = (bus.cfg_data >= MIN_MOD);

  // Modulus registers. The load logic reads the pre-write value, so a write on a wrap edge takes effect one period later.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mod
      localparam logic [N-1:0] MOD_DEF = (gi == 0) ? N'(M0_DEF) : N'(M1_DEF);
      // Accept a write to this modulus only when the value is a legal divisor (>= 2).
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_mod[gi] <= MOD_DEF;
        end else if (bus.cfg_we && (bus.cfg_sel == gi[0]) && w_cfg_ok) begin
          r_mod[gi] <= bus.cfg_data;
        end
      end
    end
  endgenerate

  // Registered one-cycle flag for a rejected (too small) modulus write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= bus.cfg_we && !w_cfg_ok;
    end
  end

  // State and datapath registers of the counter FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_q          <= '0;
      r_m_act      <= N'(M0_DEF);
      r_wave       <= 1'b0;
      r_active_sym <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_q          <= w_q_next;
      r_m_act      <= w_m_act_next;
      r_wave       <= w_wave_next;
      r_active_sym <= w_active_sym_next;
    end
  end

  // Next-state logic. clr overrides everything. Otherwise the count advances only on enabled cycles.
  always_comb begin
    w_state_next      = r_state;
    w_q_next          = r_q;
    w_m_act_next      = r_m_act;
    w_wave_next       = r_wave;
    w_active_sym_next = r_active_sym;

    if (bus.clr) begin
      w_state_next = ST_IDLE;
      w_q_next     = '0;
      w_wave_next  = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_q_next    = '0;
          w_wave_next = 1'b0;
          if (bus.en) begin
            w_state_next      = ST_RUN;
            w_m_act_next      = w_m_sel;
            w_active_sym_next = bus.sym;
          end
        end
        ST_RUN: begin
          if (!bus.en) begin
            w_state_next = ST_HOLD;
          end else if (w_at_last) begin
            w_q_next          = '0;
            w_wave_next       = ~r_wave;
            w_m_act_next      = w_m_sel;
            w_active_sym_next = bus.sym;
          end else begin
            w_q_next = r_q + ONE;
          end
        end
        ST_HOLD: begin
          // The resume cycle counts like a RUN cycle. If the pause froze the
          // last count, q is kept so that the wrap and max_tick still happen in RUN.
          if (bus.en) begin
            w_state_next = ST_RUN;
            if (!w_at_last) begin
              w_q_next = r_q + ONE;
            end
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_q_next     = '0;
          w_wave_next  = 1'b0;
        end
      endcase
    end
  end

  assign bus.max_tick   = (r_state == ST_RUN) && bus.en && !bus.clr && w_at_last;
  assign bus.q          = r_q;
  assign bus.wave       = r_wave;
  assign bus.active_sym = r_active_sym;
  assign bus.cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_fsk_tick_gen.sv
// Directed bench for fsk_tick_gen. Inputs change just after the falling edge,
// and outputs are sampled 1 ns later, well away from the rising edge.
module tb_fsk_tick_gen;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  fsk_tick_gen_if #(.N(16)) bus ();

  fsk_tick_gen #(
    .N      (16),
    .M0_DEF (163),
    .M1_DEF (326)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Step until max_tick is seen. cnt is the number of steps, or -1 if the limit expires.
  task automatic wait_tick(input int limit, output int cnt);
    int n;
    n   = 0;
    cnt = -1;
    while (cnt < 0 && n < limit) begin
      step();
      n++;
      if (bus.max_tick === 1'b1) cnt = n;
    end
    $display("tick after %0d cycles: q=%0d wave=%0b active_sym=%0b", cnt, bus.q, bus.wave, bus.active_sym);
  endtask

  // Step until q equals target. ok reports whether it got there within the limit.
  task automatic wait_q(input logic [15:0] target, input int limit, output bit ok);
    int n;
    n = 0;
    while (bus.q !== target && n < limit) begin
      step();
      n++;
    end
    ok = (bus.q === target);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.en = 1'b0; bus.clr = 1'b0; bus.sym = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_data = 16'd0;
    step(); step();
    checks++; if (bus.q !== 16'd0) begin failures++; $display("FAIL reset_q: got %0d expected 0", bus.q); end
    checks++; if (bus.wave !== 1'b0) begin failures++; $display("FAIL reset_wave: got %0b expected 0", bus.wave); end
    checks++; if (bus.max_tick !== 1'b0) begin failures++; $display("FAIL reset_max_tick: got %0b expected 0", bus.max_tick); end
    checks++; if (bus.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err: got %0b expected 0", bus.cfg_err); end
    checks++; if (bus.active_sym !== 1'b0) begin failures++; $display("FAIL reset_active_sym: got %0b expected 0", bus.active_sym); end
    $display("reset: q=%0d wave=%0b", bus.q, bus.wave);
  endtask

  task automatic test_steady();
    int cnt;
    @(negedge clk);
    reset = 1'b1; bus.en = 1'b1; bus.sym = 1'b0;
    #1;
    wait_tick(400, cnt);
    checks++; if (cnt !== 163) begin failures++; $display("FAIL first_period: got %0d expected 163", cnt); end
    checks++; if (bus.q !== 16'd162) begin failures++; $display("FAIL first_tick_q: got %0d expected 162", bus.q); end
    checks++; if (bus.wave !== 1'b0) begin failures++; $display("FAIL first_tick_wave: got %0b expected 0", bus.wave); end
    step();
    checks++; if (bus.q !== 16'd0) begin failures++; $display("FAIL wrap_q: got %0d expected 0", bus.q); end
    checks++; if (bus.wave !== 1'b1) begin failures++; $display("FAIL wrap_wave: got %0b expected 1", bus.wave); end
    wait_tick(400, cnt);
    checks++; if (cnt !== 162) begin failures++; $display("FAIL second_period: got %0d expected 162", cnt); end
    step();
    checks++; if (bus.wave !== 1'b0) begin failures++; $display("FAIL wave_period: got %0b expected 0", bus.wave); end
    checks++; if (bus.active_sym !== 1'b0) begin failures++; $display("FAIL steady_active_sym: got %0b expected 0", bus.active_sym); end
  endtask

  task automatic test_sym_switch();
    int cnt;
    bit ok;
    wait_q(16'd50, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL reach_q50: got q=%0d expected 50", bus.q); end
    bus.sym = 1'b1;
    wait_tick(400, cnt);
    checks++; if (cnt !== 112) begin failures++; $display("FAIL switch_rest: got %0d expected 112", cnt); end
    checks++; if (bus.active_sym !== 1'b0) begin failures++; $display("FAIL switch_old_sym: got %0b expected 0", bus.active_sym); end
    step();
    checks++; if (bus.active_sym !== 1'b1) begin failures++; $display("FAIL switch_new_sym: got %0b expected 1", bus.active_sym); end
    wait_tick(400, cnt);
    checks++; if (cnt !== 325) begin failures++; $display("FAIL mark_period: got %0d expected 325", cnt); end
    bus.sym = 1'b0;
    step();
    checks++; if (bus.active_sym !== 1'b0) begin failures++; $display("FAIL back_to_space: got %0b expected 0", bus.active_sym); end
  endtask

  task automatic test_config();
    int cnt;
    bit ok;
    wait_q(16'd60, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL reach_q60: got q=%0d expected 60", bus.q); end
    bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_data = 16'd100;
    step();
    bus.cfg_we = 1'b0;
    checks++; if (bus.cfg_err !== 1'b0) begin failures++; $display("FAIL good_write_err: got %0b expected 0", bus.cfg_err); end
    wait_tick(400, cnt);
    checks++; if (cnt !== 101) begin failures++; $display("FAIL period_unchanged: got %0d expected 101", cnt); end
    step();
    wait_tick(400, cnt);
    checks++; if (cnt !== 99) begin failures++; $display("FAIL period_100: got %0d expected 99", cnt); end
    step();
    bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_data = 16'd1;
    step();
    bus.cfg_we = 1'b0;
    checks++; if (bus.cfg_err !== 1'b1) begin failures++; $display("FAIL bad_write_err: got %0b expected 1", bus.cfg_err); end
    step();
    checks++; if (bus.cfg_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle: got %0b expected 0", bus.cfg_err); end
    wait_tick(400, cnt);
    checks++; if (cnt !== 97) begin failures++; $display("FAIL period_after_bad: got %0d expected 97", cnt); end
    step();
    bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_data = 16'd163;
    step();
    bus.cfg_we = 1'b0;
    wait_tick(400, cnt);
    checks++; if (cnt !== 98) begin failures++; $display("FAIL m0_kept_100: got %0d expected 98", cnt); end
    step();
  endtask

  task automatic test_pause();
    int   cnt;
    bit   ok;
    logic wv;
    wait_q(16'd70, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL reach_q70: got q=%0d expected 70", bus.q); end
    wv = bus.wave;
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (bus.q !== 16'd70) begin failures++; $display("FAIL pause_q[%0d]: got %0d expected 70", i, bus.q); end
    end
    checks++; if (bus.wave !== wv) begin failures++; $display("FAIL pause_wave: got %0b expected %0b", bus.wave, wv); end
    checks++; if (bus.max_tick !== 1'b0) begin failures++; $display("FAIL pause_tick: got %0b expected 0", bus.max_tick); end
    bus.en = 1'b1;
    wait_tick(400, cnt);
    checks++; if (cnt !== 92) begin failures++; $display("FAIL resume_period: got %0d expected 92", cnt); end
    checks++; if (bus.q !== 16'd162) begin failures++; $display("FAIL resume_tick_q: got %0d expected 162", bus.q); end
  endtask

  task automatic test_simultaneous();
    int cnt;
    bus.sym = 1'b1;
    step();
    checks++; if (bus.active_sym !== 1'b1) begin failures++; $display("FAIL sim_sym: got %0b expected 1", bus.active_sym); end
    wait_tick(400, cnt);
    checks++; if (cnt !== 325) begin failures++; $display("FAIL sim_m1_period: got %0d expected 325", cnt); end
    bus.cfg_we = 1'b1; bus.cfg_sel = 1'b1; bus.cfg_data = 16'd200;
    step();
    bus.cfg_we = 1'b0;
    checks++; if (bus.q !== 16'd0) begin failures++; $display("FAIL sim_wrap_q: got %0d expected 0", bus.q); end
    wait_tick(400, cnt);
    checks++; if (cnt !== 325) begin failures++; $display("FAIL sim_old_m1: got %0d expected 325", cnt); end
    step();
    wait_tick(400, cnt);
    checks++; if (cnt !== 199) begin failures++; $display("FAIL sim_new_m1: got %0d expected 199", cnt); end
    // clr on the wrap cycle, with a modulus write on the same edge.
    bus.clr = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_sel = 1'b1; bus.cfg_data = 16'd326;
    #1;
    checks++; if (bus.max_tick !== 1'b0) begin failures++; $display("FAIL clr_tick: got %0b expected 0", bus.max_tick); end
    step();
    bus.clr = 1'b0; bus.cfg_we = 1'b0;
    checks++; if (bus.q !== 16'd0) begin failures++; $display("FAIL clr_q: got %0d expected 0", bus.q); end
    checks++; if (bus.wave !== 1'b0) begin failures++; $display("FAIL clr_wave: got %0b expected 0", bus.wave); end
    checks++; if (bus.active_sym !== 1'b1) begin failures++; $display("FAIL clr_keeps_sym: got %0b expected 1", bus.active_sym); end
    step();
    bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_data = 16'd50;
    step();
    bus.cfg_we = 1'b0;
    checks++; if (bus.q !== 16'd1) begin failures++; $display("FAIL restart_q: got %0d expected 1", bus.q); end
  endtask

  task automatic test_async_reset();
    int cnt;
    bit ok;
    wait_q(16'd199, 400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL reach_q199: got q=%0d expected 199", bus.q); end
    bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_data = 16'd0;
    step();
    bus.cfg_we = 1'b0;
    checks++; if (bus.q !== 16'd200) begin failures++; $display("FAIL pre_reset_q: got %0d expected 200", bus.q); end
    checks++; if (bus.cfg_err !== 1'b1) begin failures++; $display("FAIL pre_reset_err: got %0b expected 1", bus.cfg_err); end
    reset = 1'b0;
    #1;
    checks++; if (bus.q !== 16'd0) begin failures++; $display("FAIL async_q: got %0d expected 0", bus.q); end
    checks++; if (bus.cfg_err !== 1'b0) begin failures++; $display("FAIL async_err: got %0b expected 0", bus.cfg_err); end
    checks++; if (bus.active_sym !== 1'b0) begin failures++; $display("FAIL async_sym: got %0b expected 0", bus.active_sym); end
    checks++; if (bus.wave !== 1'b0) begin failures++; $display("FAIL async_wave: got %0b expected 0", bus.wave); end
    checks++; if (bus.max_tick !== 1'b0) begin failures++; $display("FAIL async_tick: got %0b expected 0", bus.max_tick); end
    step();
    @(negedge clk);
    reset = 1'b1; bus.en = 1'b1; bus.sym = 1'b0;
    #1;
    wait_tick(400, cnt);
    checks++; if (cnt !== 163) begin failures++; $display("FAIL m0_restored: got %0d expected 163", cnt); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_sym_switch();
    test_config();
    test_pause();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
